// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - shared types and op classification helpers for the EX multiply/divide unit
package ex_pkg;

  typedef enum logic [3:0] {
    OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU,
    OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO
  } muldiv_op_t;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} muldiv_state_t;

  function automatic logic is_signed(muldiv_op_t op);
    return op inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
  endfunction

  function automatic logic is_acc(muldiv_op_t op);
    return op inside {OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
  endfunction

  function automatic logic is_div(muldiv_op_t op);
    return op inside {OP_DIV, OP_DIVU};
  endfunction

  // Ops that occupy the unit for multiple cycles (everything up to MSUBU)
  function automatic logic is_iter(muldiv_op_t op);
    return op <= OP_MSUBU;
  endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// rtl/ex_muldiv_if.sv - request/response bundle between EX and the multiply/divide unit
interface ex_muldiv_if #(parameter int WIDTH = 32);
  import ex_pkg::*;

  logic             start;
  muldiv_op_t       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic             readstall;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] hiout;
  logic [WIDTH-1:0] loout;
  logic             divzero;

  modport master (
    output start, op, a, b, flush,
    input  busy, done, readstall, result, hiout, loout, divzero
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, done, readstall, result, hiout, loout, divzero
  );

endinterface

// File: rtl/ex_div_step.sv
// rtl/ex_div_step.sv - one restoring-division step on unsigned magnitudes
module ex_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             din,
  input  logic [WIDTH-1:0] dvsr,
  output logic [WIDTH-1:0] rem_nxt,
  output logic             qbit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // rem < dvsr holds between steps, so a clear top bit of trial means no borrow
  always_comb begin
    shifted = {rem, din};
    trial   = shifted - {1'b0, dvsr};
    qbit    = ~trial[WIDTH];
    rem_nxt = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - iterative multiply/divide unit with HI/LO accumulator beside EX1
module ex_muldiv import ex_pkg::*; #(
  parameter int WIDTH   = 32,
  parameter int MUL_BPC = 4
) (
  input logic        clk,
  input logic        rst,
  ex_muldiv_if.slave bus
);

  localparam int CW      = $clog2(WIDTH) + 1;
  localparam int MUL_CYC = WIDTH / MUL_BPC;
  localparam int W2      = 2 * WIDTH;

  muldiv_state_t    state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi, lo;
  logic             done_q, divzero_q;
  muldiv_op_t       op_q;
  logic             neg_res, neg_rem, b_zero;
  logic [W2-1:0]    prod, mcand, pp;
  logic [WIDTH-1:0] mplier, rem, quo, dvsr;
  logic [WIDTH-1:0] rem_nxt;
  logic             qbit;
  logic             busy, accept;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [W2-1:0]    prod_s, hilo_fix;
  logic [WIDTH-1:0] quo_s, rem_s, result;

  assign busy   = (state != IDLE);
  assign accept = bus.start && !busy && !bus.flush;

  always_comb begin
    a_neg = is_signed(bus.op) && bus.a[WIDTH-1];
    b_neg = is_signed(bus.op) && bus.b[WIDTH-1];
    a_mag = a_neg ? -bus.a : bus.a;
    b_mag = b_neg ? -bus.b : bus.b;
  end

  ex_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem     (rem),
    .din     (quo[WIDTH-1]),
    .dvsr    (dvsr),
    .rem_nxt (rem_nxt),
    .qbit    (qbit)
  );

  assign pp = mcand * W2'(mplier[MUL_BPC-1:0]);

  // Sign fix-up and accumulate; a zero divisor leaves rem = |A| so HI already equals A
  always_comb begin
    prod_s   = neg_res ? -prod : prod;
    quo_s    = b_zero ? '1 : (neg_res ? -quo : quo);
    rem_s    = neg_rem ? -rem : rem;
    hilo_fix = prod_s;
    if (is_div(op_q))
      hilo_fix = {rem_s, quo_s};
    else if (is_acc(op_q))
      hilo_fix = op_q inside {OP_MADD, OP_MADDU} ? {hi, lo} + prod_s : {hi, lo} - prod_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept && is_iter(bus.op)) state_nxt = is_div(bus.op) ? DIV : MUL;
      MUL, DIV: if (cnt == CW'(1)) state_nxt = FIX;
      FIX:      state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
    if (bus.flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      hi        <= '0;
      lo        <= '0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
      op_q      <= OP_MULT;
      neg_res   <= 1'b0;
      neg_rem   <= 1'b0;
      b_zero    <= 1'b0;
      prod      <= '0;
      mcand     <= '0;
      mplier    <= '0;
      rem       <= '0;
      quo       <= '0;
      dvsr      <= '0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        divzero_q <= 1'b0;
        op_q      <= bus.op;
        neg_res   <= a_neg ^ b_neg;
        neg_rem   <= a_neg;
        b_zero    <= (bus.b == '0);
        cnt       <= is_div(bus.op) ? CW'(WIDTH) : CW'(MUL_CYC);
        prod      <= '0;
        mcand     <= {{WIDTH{1'b0}}, a_mag};
        mplier    <= b_mag;
        rem       <= '0;
        quo       <= a_mag;
        dvsr      <= b_mag;
        if (bus.op == OP_MTHI) hi <= bus.a;
        if (bus.op == OP_MTLO) lo <= bus.a;
      end
      case (state)
        MUL: begin
          prod   <= prod + pp;
          mcand  <= mcand << MUL_BPC;
          mplier <= mplier >> MUL_BPC;
          cnt    <= cnt - CW'(1);
        end
        DIV: begin
          rem <= rem_nxt;
          quo <= {quo[WIDTH-2:0], qbit};
          cnt <= cnt - CW'(1);
        end
        FIX: if (!bus.flush) begin
          {hi, lo}  <= hilo_fix;
          done_q    <= 1'b1;
          divzero_q <= b_zero && is_div(op_q);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    result = '0;
    if (bus.op == OP_MFHI)      result = hi;
    else if (bus.op == OP_MFLO) result = lo;
  end

  assign bus.busy      = busy;
  assign bus.done      = done_q;
  assign bus.readstall = bus.start && (bus.op inside {OP_MFHI, OP_MFLO}) && busy;
  assign bus.result    = result;
  assign bus.hiout     = hi;
  assign bus.loout     = lo;
  assign bus.divzero   = divzero_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - self-checking bench for ex_muldiv against an arithmetic HI/LO model
module tb_ex_muldiv;
  import ex_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ex_muldiv_if #(.WIDTH(32)) bus ();
  ex_muldiv #(.WIDTH(32), .MUL_BPC(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int failures = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic        m_dz = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: 64-bit arithmetic on the architectural HI/LO pair
  task automatic model(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo, output logic dz);
    longint sa, sb;
    logic [63:0] p, q, r, hl;
    sa = $signed(a);
    sb = $signed(b);
    hi = m_hi;
    lo = m_lo;
    dz = 1'b0;
    hl = {m_hi, m_lo};
    if (op inside {OP_MULT, OP_MADD, OP_MSUB}) p = 64'(sa * sb);
    else p = {32'h0, a} * {32'h0, b};
    case (op)
      OP_MULT, OP_MULTU: {hi, lo} = p;
      OP_MADD, OP_MADDU: {hi, lo} = hl + p;
      OP_MSUB, OP_MSUBU: {hi, lo} = hl - p;
      OP_DIV, OP_DIVU: begin
        if (b == 32'h0) begin
          lo = '1; hi = a; dz = 1'b1;
        end else if (op == OP_DIV) begin
          q = 64'(sa / sb); r = 64'(sa % sb);
          lo = q[31:0]; hi = r[31:0];
        end else begin
          lo = a / b; hi = a % b;
        end
      end
      OP_MTHI: hi = a;
      OP_MTLO: lo = a;
      default: ;
    endcase
  endtask

  task automatic do_op(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] e_hi, e_lo;
    logic        e_dz;
    int          lat;
    model(op, a, b, e_hi, e_lo, e_dz);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    if (op inside {OP_MFHI, OP_MFLO}) begin
      #1;
      check($sformatf("result op=%0d", op), bus.result, (op == OP_MFHI) ? m_hi : m_lo);
      check("readstall_idle", bus.readstall, 0);
    end
    @(posedge clk); #1;
    bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom;
    bus.op = muldiv_op_t'($urandom_range(0, 11));
    if (op <= OP_MSUBU) begin
      check("busy_after_accept", bus.busy, 1);
      lat = 0;
      while (!bus.done && lat < 40) begin
        @(posedge clk); #1;
        lat++;
      end
      check($sformatf("latency op=%0d", op), lat, (op inside {OP_DIV, OP_DIVU}) ? 33 : 9);
    end else begin
      check("busy_single", bus.busy, 0);
    end
    check($sformatf("hi op=%0d a=%0h b=%0h", op, a, b), bus.hiout, e_hi);
    check($sformatf("lo op=%0d a=%0h b=%0h", op, a, b), bus.loout, e_lo);
    check($sformatf("divzero op=%0d", op), bus.divzero, e_dz);
    m_hi = e_hi; m_lo = e_lo; m_dz = e_dz;
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h1;
      4:       return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    bus.start = 1'b0; bus.op = OP_MULT; bus.a = '0; bus.b = '0; bus.flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_hi", bus.hiout, 0);
    check("rst_lo", bus.loout, 0);
    check("rst_divzero", bus.divzero, 0);
    @(negedge clk); rst = 1'b0;

    do_op(OP_MULT, 32'hFFFF_FFFD, 32'd7);
    check("mult_hi_const", bus.hiout, 32'hFFFF_FFFF);
    check("mult_lo_const", bus.loout, 32'hFFFF_FFEB);
    do_op(OP_DIVU, 32'd100, 32'd7);
    check("divu_lo_const", bus.loout, 32'd14);
    check("divu_hi_const", bus.hiout, 32'd2);
    do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    check("div_lo_const", bus.loout, 32'hFFFF_FFFD);
    check("div_hi_const", bus.hiout, 32'hFFFF_FFFF);
    do_op(OP_DIV, 32'd5, 32'd0);
    check("divzero_const", bus.divzero, 1);
    check("divzero_lo_const", bus.loout, 32'hFFFF_FFFF);
    check("divzero_hi_const", bus.hiout, 32'd5);
    do_op(OP_MULTU, 32'd3, 32'd4);
    check("divzero_cleared", bus.divzero, 0);
    do_op(OP_MTHI, 32'h0, 32'h0);
    do_op(OP_MTLO, 32'hFFFF_FFFF, 32'h0);
    do_op(OP_MADDU, 32'd1, 32'd1);
    check("maddu_hi_const", bus.hiout, 32'd1);
    check("maddu_lo_const", bus.loout, 32'd0);
    do_op(OP_MSUB, 32'd1, 32'd1);
    check("msub_hi_const", bus.hiout, 32'd0);
    check("msub_lo_const", bus.loout, 32'hFFFF_FFFF);
    do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf_lo_const", bus.loout, 32'h8000_0000);
    check("div_ovf_hi_const", bus.hiout, 32'h0);

    // DIVU in flight: held MULT ignored, MFHI stalls, then flush
    @(negedge clk); bus.start = 1'b1; bus.op = OP_DIVU; bus.a = 32'd100; bus.b = 32'd7;
    @(posedge clk); #1; bus.start = 1'b0;
    @(negedge clk); bus.start = 1'b1; bus.op = OP_MULT; bus.a = 32'd3; bus.b = 32'd3;
    @(posedge clk); #1;
    check("held_mult_busy", bus.busy, 1);
    @(posedge clk); #1;
    @(negedge clk); bus.op = OP_MFHI; #1;
    check("readstall_busy", bus.readstall, 1);
    bus.start = 1'b0; bus.flush = 1'b1;
    @(posedge clk); #1; bus.flush = 1'b0;
    check("flush_busy", bus.busy, 0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done) seen = 1'b1;
    end
    check("flush_no_done", seen, 0);
    check("flush_hi", bus.hiout, m_hi);
    check("flush_lo", bus.loout, m_lo);

    // Flush and Start on the same edge: not accepted
    @(negedge clk); bus.start = 1'b1; bus.op = OP_MTHI; bus.a = 32'hDEAD_BEEF; bus.flush = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0; bus.flush = 1'b0;
    check("flush_start_hi", bus.hiout, m_hi);
    check("flush_start_busy", bus.busy, 0);

    // Flush while in FIX: no write, no Done
    @(negedge clk); bus.start = 1'b1; bus.op = OP_MULT; bus.a = 32'd5; bus.b = 32'd6;
    @(posedge clk); #1; bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("fix_busy", bus.busy, 1);
    bus.flush = 1'b1;
    @(posedge clk); #1; bus.flush = 1'b0;
    check("fix_flush_done", bus.done, 0);
    check("fix_flush_busy", bus.busy, 0);
    check("fix_flush_hi", bus.hiout, m_hi);
    check("fix_flush_lo", bus.loout, m_lo);

    // Asynchronous reset mid-multiply
    do_op(OP_MTHI, 32'h1234_5678, 32'h0);
    do_op(OP_MTLO, 32'h9ABC_DEF0, 32'h0);
    @(negedge clk); bus.start = 1'b1; bus.op = OP_MULTU; bus.a = 32'd9; bus.b = 32'd9;
    @(posedge clk); #1; bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #3; rst = 1'b1; #1;
    check("arst_busy", bus.busy, 0);
    check("arst_done", bus.done, 0);
    check("arst_hi", bus.hiout, 0);
    check("arst_lo", bus.loout, 0);
    m_hi = '0; m_lo = '0; m_dz = 1'b0;
    @(negedge clk); rst = 1'b0;
    do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    repeat (60) do_op(muldiv_op_t'($urandom_range(0, 11)), rnd_val(), rnd_val());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
